// File: rtl/alu_tmr_sequencer.sv
// Runs one request at a time through three replicated ALUs, votes their results,
// retries split votes a bounded number of times and counts corrected/uncorrectable outcomes.
module alu_tmr_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 2,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [15:0]      REQ_A,
    input  logic [15:0]      REQ_B,
    input  logic [2:0]       REQ_OP,
    output logic [15:0]      ALU_A,
    output logic [15:0]      ALU_B,
    output logic [2:0]       ALU_OP,
    output logic             DATA_READY,
    input  logic [15:0]      R0_LO,
    input  logic [15:0]      R1_LO,
    input  logic [15:0]      R2_LO,
    input  logic [14:0]      R0_HI,
    input  logic [14:0]      R1_HI,
    input  logic [14:0]      R2_HI,
    input  logic             R0_CO,
    input  logic             R1_CO,
    input  logic             R2_CO,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [15:0]      RES_LO,
    output logic [14:0]      RES_HI,
    output logic             RES_COUT,
    output logic             RES_FAULT,
    output logic [1:0]       RES_FID,
    output logic [CNT_W-1:0] CORR_CNT,
    output logic [CNT_W-1:0] UNCORR_CNT
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_VOTE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [15:0]      a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [2:0]       retry_q, retry_d;
    logic [31:0]      w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic [31:0]      res_q, res_d;
    logic             fault_q, fault_d;
    logic [1:0]       fid_q, fid_d;
    logic [CNT_W-1:0] corr_q, corr_d, uncorr_q, uncorr_d;
    logic             e01, e02, e12;

    // Compared word {HI, LO, CO}; fields the opcode does not produce are forced to zero
    // so undriven replica outputs never take part in the vote.
    function automatic logic [31:0] mask_word(input logic [2:0] op, input logic [14:0] hi,
                                              input logic [15:0] lo, input logic co);
        logic [14:0] h;
        logic        c;
        h = (op == OP_MUL) ? hi : 15'd0;
        c = (op == OP_ADD || op == OP_SUB) ? co : 1'b0;
        return {h, lo, c};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign e01 = (w0_q == w1_q);
    assign e02 = (w0_q == w2_q);
    assign e12 = (w1_q == w2_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        settle_d = settle_q;
        retry_d  = retry_q;
        w0_d     = w0_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        res_d    = res_q;
        fault_d  = fault_q;
        fid_d    = fid_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    a_d      = REQ_A;
                    b_d      = REQ_B;
                    op_d     = REQ_OP;
                    retry_d  = 3'd0;
                    settle_d = '0;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    w0_d     = mask_word(op_q, R0_HI, R0_LO, R0_CO);
                    w1_d     = mask_word(op_q, R1_HI, R1_LO, R1_CO);
                    w2_d     = mask_word(op_q, R2_HI, R2_LO, R2_CO);
                    settle_d = '0;
                    state_d  = S_VOTE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_VOTE: begin
                if (e01 && e12) begin
                    res_d   = w0_q;
                    fid_d   = 2'd3;
                    state_d = S_DONE;
                end else if (e01 || e02 || e12) begin
                    // The replica outside the agreeing pair is the one reported
                    res_d   = e12 ? w1_q : w0_q;
                    fid_d   = e01 ? 2'd2 : (e02 ? 2'd1 : 2'd0);
                    corr_d  = sat_inc(corr_q);
                    state_d = S_DONE;
                end else if (retry_q < 3'(MAX_RETRY)) begin
                    retry_d = retry_q + 3'd1;
                    state_d = S_DRIVE;
                end else begin
                    res_d    = (w0_q & w1_q) | (w0_q & w2_q) | (w1_q & w2_q);
                    fault_d  = 1'b1;
                    fid_d    = 2'd3;
                    uncorr_d = sat_inc(uncorr_q);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (RES_READY) begin
                    fault_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            settle_q <= '0;
            retry_q  <= '0;
            w0_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            res_q    <= '0;
            fault_q  <= 1'b0;
            fid_q    <= 2'd3;
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            settle_q <= settle_d;
            retry_q  <= retry_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            res_q    <= res_d;
            fault_q  <= fault_d;
            fid_q    <= fid_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
        end
    end

    assign REQ_READY  = (state_q == S_IDLE);
    assign DATA_READY = (state_q == S_DRIVE);
    assign RES_VALID  = (state_q == S_DONE);
    assign ALU_A      = a_q;
    assign ALU_B      = b_q;
    assign ALU_OP     = op_q;
    assign RES_HI     = res_q[31:17];
    assign RES_LO     = res_q[16:1];
    assign RES_COUT   = res_q[0];
    assign RES_FAULT  = fault_q;
    assign RES_FID    = fid_q;
    assign CORR_CNT   = corr_q;
    assign UNCORR_CNT = uncorr_q;

endmodule
